// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transceiver.
// Holds the parity mode enum, both FSM state enums, the baud divider
// calculation and the parity bit helper used by TX and RX.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_ODD,
    PAR_EVEN
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Clocks per serial bit; integer truncation is intended.
  function automatic int bauddiv(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Parity bit for a frame. Callers pass data with unused upper bits zeroed.
  function automatic logic parity_bit(input logic [7:0] data, input parity_e mode);
    case (mode)
      PAR_EVEN: return ^data;
      PAR_ODD:  return ~^data;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_xcvr_if.sv
// uart_xcvr_if: byte-level TX and RX handshakes of the UART transceiver.
// master = the client that feeds TX bytes and drains RX bytes;
// slave  = the transceiver itself.
interface uart_xcvr_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_perr;
  logic       rx_ferr;
  logic       rx_overrun;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_perr, rx_ferr, rx_overrun
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_perr, rx_ferr, rx_overrun
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small synchronous FIFO holding received frames.
// Pointers carry one extra wrap bit so full and empty are distinguishable;
// a push into a full FIFO is accepted when a pop happens in the same cycle.
// The head output reads as zero while the FIFO is empty.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Storage write.
  // NOTE: the array has no reset; entries are only visible after a push,
  // and the empty gating on head keeps stale contents off the output.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointer update; natural overflow gives wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_xcvr.sv
// uart_xcvr: UART transmitter and receiver with an RX frame FIFO.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity bit,
// STOP_BITS stop bits; each bit lasts CLK_HZ/BAUD clocks.
// Optional feature: define UART_LOOPBACK_EN to add a 'loopback' input that
// routes tx_pin_out into the receiver in place of rx_pin_in.
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int      CLK_HZ    = 50_000_000,
  parameter int      BAUD      = 115_200,
  parameter int      DATA_BITS = 8,
  parameter parity_e PARITY    = PAR_NONE,
  parameter int      STOP_BITS = 1,
  parameter int      RX_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
`ifdef UART_LOOPBACK_EN
  input  logic       loopback,
`endif
  input  logic       rx_pin_in,
  output logic       tx_pin_out,
  uart_xcvr_if.slave bus
);

  localparam int               BAUD_DIV  = bauddiv(CLK_HZ, BAUD);
  localparam int               CNT_W     = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic [7:0]       DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam int               FIFO_W    = 10;

  // ---------------------------------------------------------------- TX ---
  tx_state_e        tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic             tx_stop;
  logic [7:0]       tx_shift;
  logic             tx_par;
  logic             tx_ready_q;

  assign bus.tx_ready = tx_ready_q;

  // TX FSM; tx_pin_out is set on entry to each bit so it is glitch-free.
  // NOTE: all state here is updated with <= so every branch sees the
  // values from before this clock edge, exactly like the flops it becomes.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state   <= TX_IDLE;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      tx_stop    <= 1'b0;
      tx_shift   <= '0;
      tx_par     <= 1'b0;
      tx_pin_out <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (bus.tx_valid) begin
            tx_shift   <= bus.tx_data & DATA_MASK;
            tx_par     <= parity_bit(bus.tx_data & DATA_MASK, PARITY);
            tx_cnt     <= '0;
            tx_pin_out <= 1'b0;
            tx_ready_q <= 1'b0;
            tx_state   <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_pin_out <= tx_shift[0];
            tx_state   <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == BIT_LAST) begin
              tx_stop    <= 1'b0;
              tx_pin_out <= (PARITY == PAR_NONE) ? 1'b1 : tx_par;
              tx_state   <= (PARITY == PAR_NONE) ? TX_STOP : TX_PARITY;
            end else begin
              tx_bit     <= tx_bit + 3'd1;
              tx_shift   <= tx_shift >> 1;
              tx_pin_out <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        TX_PARITY: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt     <= '0;
            tx_stop    <= 1'b0;
            tx_pin_out <= 1'b1;
            tx_state   <= TX_STOP;
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt <= '0;
            if (tx_stop == STOP_LAST) begin
              tx_ready_q <= 1'b1;
              tx_state   <= TX_IDLE;
            end else begin
              tx_stop <= 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        default: begin
          tx_pin_out <= 1'b1;
          tx_ready_q <= 1'b1;
          tx_state   <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX ---
  logic rx_src;
  logic rx_meta;
  logic rx_sync;
  logic rx_prev;

`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback ? tx_pin_out : rx_pin_in;
`else
  assign rx_src = rx_pin_in;
`endif

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_src;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  rx_state_e         rx_state;
  logic [CNT_W-1:0]  rx_cnt;
  logic [2:0]        rx_bit;
  logic [7:0]        rx_shift;
  logic              rx_pbit;
  logic              rx_push;
  logic [FIFO_W-1:0] rx_push_data;
  logic              rx_perr_calc;

  assign rx_perr_calc = (PARITY != PAR_NONE) && (rx_pbit != parity_bit(rx_shift, PARITY));

  // RX FSM: start bit is sampled half a bit after the edge, then every
  // BAUD_DIV clocks, which lands each sample mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_pbit      <= 1'b0;
      rx_push      <= 1'b0;
      rx_push_data <= '0;
    end else begin
      rx_push <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_cnt   <= '0;
            rx_shift <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt           <= '0;
            rx_shift[rx_bit] <= rx_sync;
            if (rx_bit == BIT_LAST) begin
              rx_state <= (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_PARITY: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt   <= '0;
            rx_pbit  <= rx_sync;
            rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt       <= '0;
            rx_push      <= 1'b1;
            rx_push_data <= {rx_perr_calc, !rx_sync, rx_shift};
            rx_state     <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------- FIFO ---
  logic [FIFO_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              rx_pop;
  logic              overrun_q;

  assign rx_pop = bus.rx_ready && !fifo_empty;

  uart_rx_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (rx_push_data),
    .pop       (bus.rx_ready),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sticky overrun: a frame dropped on a full FIFO; cleared by a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else if (rx_push && fifo_full && !rx_pop) begin
      overrun_q <= 1'b1;
    end else if (rx_pop && overrun_q) begin
      overrun_q <= 1'b0;
    end
  end

  assign bus.rx_valid   = !fifo_empty;
  assign bus.rx_data    = fifo_head[7:0];
  assign bus.rx_ferr    = fifo_head[8];
  assign bus.rx_perr    = fifo_head[9];
  assign bus.rx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_xcvr.sv
// tb_uart_xcvr: self-checking bench for uart_xcvr.
// dut_a: 50 MHz / 115200 (434 clocks per bit), even parity - TX waveform,
//        glitch rejection, loopback stream and reset mid-frame.
// dut_b: 16 clocks per bit, odd parity - RX vectors, overrun and random
//        traffic against a frame-level reference model.
module tb_uart_xcvr;
  import uart_pkg::*;

  localparam int DIV_A  = 434;
  localparam int DIV_B  = 16;
  localparam int FBITS  = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_a, rst_b;
  logic a_rx_drv, a_lb, a_tx_pin, a_rx_pin;
  logic b_rx_drv, b_ext_lb, b_tx_pin, b_rx_pin;

  uart_xcvr_if bus_a ();
  uart_xcvr_if bus_b ();

  assign b_rx_pin = b_ext_lb ? b_tx_pin : b_rx_drv;
`ifdef UART_LOOPBACK_EN
  assign a_rx_pin = a_rx_drv;
`else
  assign a_rx_pin = a_lb ? a_tx_pin : a_rx_drv;
`endif

  uart_xcvr #(
    .CLK_HZ (50_000_000), .BAUD (115_200), .DATA_BITS (8),
    .PARITY (PAR_EVEN), .STOP_BITS (1), .RX_DEPTH (4)
  ) dut_a (
    .clk        (clk),
    .rst        (rst_a),
`ifdef UART_LOOPBACK_EN
    .loopback   (a_lb),
`endif
    .rx_pin_in  (a_rx_pin),
    .tx_pin_out (a_tx_pin),
    .bus        (bus_a)
  );

  uart_xcvr #(
    .CLK_HZ (1_600_000), .BAUD (100_000), .DATA_BITS (8),
    .PARITY (PAR_ODD), .STOP_BITS (1), .RX_DEPTH (4)
  ) dut_b (
    .clk        (clk),
    .rst        (rst_b),
`ifdef UART_LOOPBACK_EN
    .loopback   (1'b0),
`endif
    .rx_pin_in  (b_rx_pin),
    .tx_pin_out (b_tx_pin),
    .bus        (bus_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Expected line bits, LSB first: start, data, parity, stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit even);
    logic p;
    p = even ? ^d : ~^d;
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic pop_a();
    bus_a.rx_ready = 1'b1;
    tick();
    bus_a.rx_ready = 1'b0;
  endtask

  task automatic pop_b();
    bus_b.rx_ready = 1'b1;
    tick();
    bus_b.rx_ready = 1'b0;
  endtask

  task automatic send_a(input logic [7:0] d);
    int t;
    t = 0;
    bus_a.tx_data  = d;
    bus_a.tx_valid = 1'b1;
    while (!bus_a.tx_ready && t < 6000) begin tick(); t++; end
    check("send_a ready timeout", bus_a.tx_ready, 1'b1);
    tick();
    bus_a.tx_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d);
    int t;
    t = 0;
    bus_b.tx_data  = d;
    bus_b.tx_valid = 1'b1;
    while (!bus_b.tx_ready && t < 1000) begin tick(); t++; end
    check("send_b ready timeout", bus_b.tx_ready, 1'b1);
    tick();
    bus_b.tx_valid = 1'b0;
  endtask

  // Drives one odd-parity frame on dut_b's line, then one idle bit.
  task automatic drive_frame_b(input logic [7:0] d, input bit flip, input bit stop_low);
    logic [10:0] f;
    f = frame_bits(d, 1'b0);
    f[9]  = f[9] ^ flip;
    f[10] = ~stop_low;
    for (int k = 0; k < FBITS; k++) begin
      b_rx_drv = f[k];
      ticks(DIV_B);
    end
    b_rx_drv = 1'b1;
    ticks(DIV_B);
  endtask

  task automatic wait_valid_b(input string name);
    int t;
    t = 0;
    while (!bus_b.rx_valid && t < 2000) begin tick(); t++; end
    check({name, " rx_valid"}, bus_b.rx_valid, 1'b1);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         flip;
    bit         stop_low;
    logic [7:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
  } rx_vec_t;

  // TX waveform of 0xA5 on dut_a, bit levels and exact bit lengths.
  task automatic test_tx_a5();
    logic [10:0] f;
    int          err;
    f = frame_bits(8'hA5, 1'b1);
    bus_a.tx_data  = 8'hA5;
    bus_a.tx_valid = 1'b1;
    tick();
    bus_a.tx_valid = 1'b0;
    check("tx_ready low after accept", bus_a.tx_ready, 1'b0);
    for (int k = 0; k < FBITS; k++) begin
      err = 0;
      for (int c = 0; c < DIV_A; c++) begin
        if (a_tx_pin !== f[k]) err++;
        if (k == FBITS - 1 && c == DIV_A - 1) check("tx_ready low in last stop clock", bus_a.tx_ready, 1'b0);
        tick();
      end
      check($sformatf("tx A5 bit %0d bad clocks", k), err, 0);
    end
    check("tx_ready back in idle", bus_a.tx_ready, 1'b1);
    check("tx line idle high", a_tx_pin, 1'b1);
  endtask

  // 100-clock low pulse on dut_a's idle line must not create a frame.
  task automatic test_glitch();
    int seen;
    seen = 0;
    a_rx_drv = 1'b0;
    ticks(100);
    a_rx_drv = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (bus_a.rx_valid) seen++;
      tick();
    end
    check("glitch rx_valid cycles", seen, 0);
  endtask

  // Back-to-back loopback stream with tx_valid held high.
  task automatic test_loopback();
    logic [7:0] bytes [3];
    int         acc   [3];
    int         t;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h81;
    a_lb = 1'b1;
    bus_a.tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      t = 0;
      bus_a.tx_data = bytes[i];
      while (!bus_a.tx_ready && t < 6000) begin tick(); t++; end
      check($sformatf("lb accept %0d timeout", i), bus_a.tx_ready, 1'b1);
      tick();
      acc[i] = cyc;
    end
    bus_a.tx_valid = 1'b0;
    check("lb spacing 0-1", acc[1] - acc[0], FBITS * DIV_A + 1);
    check("lb spacing 1-2", acc[2] - acc[1], FBITS * DIV_A + 1);
    ticks(FBITS * DIV_A);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lb rx_valid %0d", i), bus_a.rx_valid, 1'b1);
      check($sformatf("lb rx_data %0d", i), bus_a.rx_data, bytes[i]);
      check($sformatf("lb flags %0d", i), {bus_a.rx_perr, bus_a.rx_ferr}, 2'b00);
      pop_a();
    end
    check("lb fifo drained", bus_a.rx_valid, 1'b0);
  endtask

  // Reset while TX and RX are both mid-frame.
  task automatic test_reset_mid();
    int seen;
    send_a(8'h5A);
    ticks(FBITS * DIV_A + 20);
    check("pre-reset frame stored", bus_a.rx_valid, 1'b1);
    send_a(8'hC3);
    ticks(2000);
    check("pre-reset line low mid-frame", a_tx_pin, 1'b0);
    rst_a = 1'b1;
    tick();
    check("reset tx_pin high next cycle", a_tx_pin, 1'b1);
    check("reset fifo empty", bus_a.rx_valid, 1'b0);
    rst_a = 1'b0;
    tick();
    check("post-reset tx_ready", bus_a.tx_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < FBITS * DIV_A; i++) begin
      if (bus_a.rx_valid || a_tx_pin !== 1'b1) seen++;
      tick();
    end
    check("post-reset no partial frame", seen, 0);
    a_lb = 1'b0;
  endtask

  task automatic test_rx_table();
    rx_vec_t vecs [6];
    vecs[0] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1};
    vecs[3] = '{8'h66, 1'b0, 1'b0, 8'h66, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive_frame_b(vecs[i].data, vecs[i].flip, vecs[i].stop_low);
      wait_valid_b($sformatf("vec %0d", i));
      check($sformatf("vec %0d rx_data", i), bus_b.rx_data, vecs[i].exp_data);
      check($sformatf("vec %0d rx_perr", i), bus_b.rx_perr, vecs[i].exp_perr);
      check($sformatf("vec %0d rx_ferr", i), bus_b.rx_ferr, vecs[i].exp_ferr);
      pop_b();
      check($sformatf("vec %0d empty after pop", i), bus_b.rx_valid, 1'b0);
    end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) begin
      drive_frame_b(8'(i), 1'b0, 1'b0);
      if (i == 4) check("no overrun at exactly full", bus_b.rx_overrun, 1'b0);
    end
    ticks(2);
    check("overrun set", bus_b.rx_overrun, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("overrun pop %0d valid", i), bus_b.rx_valid, 1'b1);
      check($sformatf("overrun pop %0d data", i), bus_b.rx_data, 8'(i));
      pop_b();
      if (i == 1) check("overrun cleared by pop", bus_b.rx_overrun, 1'b0);
    end
    check("overrun fifo drained", bus_b.rx_valid, 1'b0);
  endtask

  // Random frames on the line; expectations from the injected faults.
  task automatic test_rx_random();
    logic [7:0] d;
    bit         flip, sl;
    for (int i = 0; i < 16; i++) begin
      d    = 8'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      sl   = ($urandom_range(0, 3) == 0);
      drive_frame_b(d, flip, sl);
      wait_valid_b("rnd");
      check($sformatf("rnd %0d data", i), bus_b.rx_data, d);
      check($sformatf("rnd %0d flags", i), {bus_b.rx_perr, bus_b.rx_ferr}, {flip, sl});
      pop_b();
    end
  endtask

  // Random bytes through dut_b TX, looped externally into its RX, drained
  // with random latency; the scoreboard is a plain queue of sent bytes.
  task automatic test_loop_random();
    logic [7:0] exp_q [$];
    int         n;
    n = 24;
    b_ext_lb = 1'b1;
    fork
      begin
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
          d = 8'($urandom);
          exp_q.push_back(d);
          send_b(d);
        end
      end
      begin
        int         got, t, dly;
        logic [7:0] e;
        got = 0;
        t   = 0;
        while (got < n && t < 40000) begin
          if (bus_b.rx_valid) begin
            dly = $urandom_range(0, 40);
            ticks(dly);
            t += dly;
            check("loop queue nonempty", (exp_q.size() > 0), 1'b1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            check($sformatf("loop %0d data", got), bus_b.rx_data, e);
            check($sformatf("loop %0d flags", got), {bus_b.rx_perr, bus_b.rx_ferr}, 2'b00);
            pop_b();
            got++;
          end else begin
            tick();
            t++;
          end
        end
        check("loop frames received", got, n);
      end
    join
    check("loop no overrun", bus_b.rx_overrun, 1'b0);
    b_ext_lb = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    a_rx_drv = 1'b1; b_rx_drv = 1'b1;
    a_lb = 1'b0; b_ext_lb = 1'b0;
    bus_a.tx_data = '0; bus_a.tx_valid = 1'b0; bus_a.rx_ready = 1'b0;
    bus_b.tx_data = '0; bus_b.tx_valid = 1'b0; bus_b.rx_ready = 1'b0;
    ticks(3);
    check("reset tx_pin_out", a_tx_pin, 1'b1);
    check("reset rx_valid", bus_a.rx_valid, 1'b0);
    check("reset rx_data", bus_a.rx_data, 8'h00);
    check("reset flags", {bus_a.rx_perr, bus_a.rx_ferr, bus_a.rx_overrun}, 3'b000);
    check("reset b rx_valid", bus_b.rx_valid, 1'b0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
    check("tx_ready after reset a", bus_a.tx_ready, 1'b1);
    check("tx_ready after reset b", bus_b.tx_ready, 1'b1);
    check("tx line idle after reset", b_tx_pin, 1'b1);

    test_tx_a5();
    test_glitch();
    test_loopback();
    test_reset_mid();

    test_rx_table();
    test_overrun();
    test_rx_random();
    test_loop_random();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_xcvr.md
UART_XCVR -- requirements
Module: uart_xcvr

Interface
REQ-001 CLK_HZ, 50_000_000, system clock frequency in Hz.
REQ-002 BAUD, 115_200, line rate; BAUD_DIV = CLK_HZ/BAUD (integer truncation), SHALL be >= 8.
REQ-003 DATA_BITS, 8, data bits per frame, legal range 5..8.
REQ-004 PARITY, PAR_NONE, parity mode from uart_pkg: PAR_NONE, PAR_ODD or PAR_EVEN.
REQ-005 STOP_BITS, 1, stop bits per frame, 1 or 2.
REQ-006 RX_DEPTH, 4, RX FIFO entries, power of two, 2..16.
REQ-007 clk  in  1  single system clock; all logic on its rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 rx_pin_in  in  1  asynchronous serial input, idle high.
REQ-010 tx_pin_out  out  1  serial output, idle high.
REQ-011 tx_data  in  8  byte to send; only bits [DATA_BITS-1:0] are transmitted.
REQ-012 tx_valid / tx_ready  in / out  1 / 1  TX handshake; transfer on the cycle both are high.
REQ-013 rx_data  out  8  FIFO head; upper unused bits are 0.
REQ-014 rx_valid / rx_ready  out / in  1 / 1  RX handshake; pop on the cycle both are high.
REQ-015 rx_perr, rx_ferr  out  1 each  parity / framing error flags stored with the head entry.
REQ-016 rx_overrun  out  1  sticky; set when a frame completes while the FIFO is full.

Function
REQ-017 TX FSM SHALL use states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=PAR_NONE.
REQ-018 tx_ready SHALL be high only in IDLE; an accepted byte is latched, and START begins on the next cycle.
REQ-019 Each TX bit SHALL last exactly BAUD_DIV clocks; data goes LSB first, followed by STOP_BITS high bits.
REQ-020 Parity bit SHALL be the XOR of the data bits for EVEN and its inverse for ODD.
REQ-021 Back-to-back: a tx_valid held high SHALL be accepted in the IDLE cycle after the last stop bit; frame spacing = frame bits*BAUD_DIV + 1 clocks.
REQ-022 rx_pin_in SHALL pass a 2-flop synchronizer; a high-to-low transition of the synchronized line in RX IDLE starts reception.
REQ-023 RX FSM SHALL use states IDLE, START, DATA, PARITY, STOP; each bit is sampled at BAUD_DIV/2 clocks into its bit period.
REQ-024 If the start-bit sample is high, the glitch is rejected: return to IDLE and write nothing to the FIFO.
REQ-025 Only the first stop bit SHALL be checked; a low sample sets ferr for the frame; RX re-arms in IDLE right after that sample.
REQ-026 Completed frames SHALL be pushed as {perr, ferr, data}; if the FIFO is full the frame is dropped and rx_overrun is set.
REQ-027 rx_overrun SHALL clear only on reset or on a pop while rx_overrun=1.
REQ-028 Simultaneous push and pop on a full FIFO SHALL succeed with no overrun; pointers wrap modulo RX_DEPTH.
REQ-029 rx_valid SHALL equal FIFO non-empty, with no combinational path from rx_ready to rx_valid.

Reset
REQ-030 On reset: tx_pin_out=1; tx_ready=1 in the cycle after reset deasserts; rx_valid=0; rx_data=0; all error flags=0; FIFO empty; both FSMs in IDLE; counters=0.
REQ-031 Reset mid-frame SHALL abort both directions immediately, discard partial data and drive tx_pin_out high on the next cycle.

Configuration
REQ-032 When UART_LOOPBACK_EN is defined, add input loopback (1 bit); when loopback=1, the RX path takes tx_pin_out internally instead of rx_pin_in, and tx_pin_out still toggles.
REQ-033 When UART_LOOPBACK_EN is undefined, the loopback port and its mux SHALL be absent.

Structure
REQ-034 Package uart_pkg SHALL hold the parity_e enum, the tx_state_e and rx_state_e enums, and the function bauddiv(CLK_HZ, BAUD).
REQ-035 One sub-module, uart_rx_fifo, SHALL implement the RX FIFO (parametrised width and depth); both FSMs stay in uart_xcvr.

Verification
REQ-036 TX: DATA_BITS=8, PARITY=PAR_EVEN, BAUD_DIV=434; send 0xA5 -> line shows 0,1,0,1,0,0,1,0,1,0,1, with every bit 434 clocks long.
REQ-037 RX: drive 0x3C with odd parity and a correct parity bit -> rx_valid with rx_data=0x3C, perr=0, ferr=0; flipping the parity bit -> perr=1.
REQ-038 Glitch: low pulse of 100 clocks on an idle line -> no FIFO write, rx_valid stays 0.
REQ-039 Overrun: RX_DEPTH=4, five frames 0x01..0x05 with rx_ready=0 -> rx_overrun=1, pops return 0x01..0x04, and the first pop clears rx_overrun.
REQ-040 Framing: stop bit driven low on 0x55 -> rx_data=0x55 with ferr=1; the next valid frame 0x66 is received clean.
REQ-041 Loopback (UART_LOOPBACK_EN defined, loopback=1): stream 0x00, 0xFF, 0x81 back-to-back -> identical bytes on the RX side; assert rst mid-frame -> tx_pin_out=1 next cycle and FIFO empty.
